// File: rtl/instr_mem_sync_if.sv
// ----------------------------------------------------------------------------
// instr_mem_sync_if
// Fetch/stall and program-load bus between the PC stage and the instruction
// memory.
//   Address     : byte address of the fetch
//   Fetch       : fetch request
//   Stall       : hold the read outputs; a fetch is ignored while high
//   LoadEn      : program-load write enable
//   LoadAddr    : byte address of the load
//   LoadData    : word to write
//   Instruction : registered instruction word
//   InstrValid  : Instruction holds a fresh result of last cycle's fetch
//   AddrFault   : the registered fetch was misaligned or out of range
//   Ready       : init complete; fetches and loads are accepted
// ----------------------------------------------------------------------------
interface instr_mem_sync_if #(
    parameter int DATA_WIDTH = 32
);
    logic [31:0]           Address;
    logic                  Fetch;
    logic                  Stall;
    logic                  LoadEn;
    logic [31:0]           LoadAddr;
    logic [DATA_WIDTH-1:0] LoadData;
    logic [DATA_WIDTH-1:0] Instruction;
    logic                  InstrValid;
    logic                  AddrFault;
    logic                  Ready;

    modport master (
        output Address, Fetch, Stall, LoadEn, LoadAddr, LoadData,
        input  Instruction, InstrValid, AddrFault, Ready
    );

    modport slave (
        input  Address, Fetch, Stall, LoadEn, LoadAddr, LoadData,
        output Instruction, InstrValid, AddrFault, Ready
    );
endinterface

// File: rtl/instr_mem_sync.sv
// ----------------------------------------------------------------------------
// instr_mem_sync
// Clocked instruction memory for the MIPS fetch stage, sitting between the
// PC register and the IF/ID register.
//   Clk   : system clock, all state changes on the rising edge
//   Reset : synchronous, active-high; aborts everything and restarts init
//   bus   : instr_mem_sync_if slave (fetch/stall port, program-load port,
//           Instruction/InstrValid/AddrFault/Ready results)
// After reset the memory fills itself with memory[i] = i*INIT_MULT over DEPTH
// cycles, then raises Ready. Reads have one cycle of latency and are
// read-before-write against a same-cycle load.
// ----------------------------------------------------------------------------
module instr_mem_sync #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 128,
    parameter int                    INIT_MULT  = 3,
    parameter logic [DATA_WIDTH-1:0] FAULT_WORD = '0
) (
    input  logic              Clk,
    input  logic              Reset,
    instr_mem_sync_if.slave   bus
);
    localparam int IDX_BITS = $clog2(DEPTH);

    typedef enum logic {
        S_INIT  = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t                r_state;
    logic [IDX_BITS-1:0]   r_cnt;
    logic [DATA_WIDTH-1:0] r_instr;
    logic                  r_valid;
    logic                  r_fault;
    logic                  r_ready;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [IDX_BITS-1:0]   w_fetch_idx;
    logic [IDX_BITS-1:0]   w_load_idx;
    logic                  w_fetch_fault;
    logic                  w_load_fault;
    logic [DATA_WIDTH-1:0] w_init_word;
    logic                  w_we;
    logic [IDX_BITS-1:0]   w_waddr;
    logic [DATA_WIDTH-1:0] w_wdata;

    // Byte address -> word index; any set bit above the index or in the
    // byte offset is a fault.
    assign w_fetch_idx   = bus.Address[IDX_BITS+1:2];
    assign w_load_idx    = bus.LoadAddr[IDX_BITS+1:2];
    assign w_fetch_fault = (|bus.Address[1:0])  | (|bus.Address[31:IDX_BITS+2]);
    assign w_load_fault  = (|bus.LoadAddr[1:0]) | (|bus.LoadAddr[31:IDX_BITS+2]);
    assign w_init_word   = DATA_WIDTH'(r_cnt) * DATA_WIDTH'(INIT_MULT);

    // Single write port shared by the init sweep and program loads.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_cnt;
        w_wdata = w_init_word;
        if (!Reset) begin
            if (r_state == S_INIT) begin
                w_we = 1'b1;
            end else if (bus.LoadEn && !w_load_fault) begin
                w_we    = 1'b1;
                w_waddr = w_load_idx;
                w_wdata = bus.LoadData;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_INIT;
            r_cnt   <= '0;
            r_instr <= '0;
            r_valid <= 1'b0;
            r_fault <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                S_INIT: begin
                    r_cnt   <= r_cnt + 1'b1;
                    r_valid <= 1'b0;
                    r_fault <= 1'b0;
                    if (r_cnt == IDX_BITS'(DEPTH - 1)) begin
                        r_state <= S_READY;
                        r_ready <= 1'b1;
                    end
                end
                S_READY: begin
                    // Stall freezes all read outputs; the old array value is
                    // sampled here, so a same-cycle load is not yet visible.
                    if (!bus.Stall) begin
                        if (bus.Fetch) begin
                            r_valid <= 1'b1;
                            r_fault <= w_fetch_fault;
                            r_instr <= w_fetch_fault ? FAULT_WORD : r_mem[w_fetch_idx];
                        end else begin
                            r_valid <= 1'b0;
                            r_fault <= 1'b0;
                        end
                    end
                end
                default: r_state <= S_INIT;
            endcase
        end
    end

    assign bus.Instruction = r_instr;
    assign bus.InstrValid  = r_valid;
    assign bus.AddrFault   = r_fault;
    assign bus.Ready       = r_ready;

endmodule

// File: tb/tb_instr_mem_sync.sv
// ----------------------------------------------------------------------------
// tb_instr_mem_sync
// Directed bench for instr_mem_sync with default parameters.
// ----------------------------------------------------------------------------
module tb_instr_mem_sync;
    logic Clk;
    logic Reset;

    instr_mem_sync_if #(.DATA_WIDTH(32)) bus ();

    instr_mem_sync #(
        .DATA_WIDTH(32),
        .DEPTH(128),
        .INIT_MULT(3),
        .FAULT_WORD(32'h0)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .bus(bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] addr;
        logic        fetch;
        logic        stall;
        logic        len;
        logic [31:0] laddr;
        logic [31:0] ldata;
        logic [31:0] e_instr;
        logic        e_valid;
        logic        e_fault;
    } vec_t;

    vec_t vecs[$];
    int   n_vec;
    int   n_err;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.Address  = 32'h0;
        bus.Fetch    = 1'b0;
        bus.Stall    = 1'b0;
        bus.LoadEn   = 1'b0;
        bus.LoadAddr = 32'h0;
        bus.LoadData = 32'h0;
    endtask

    // Counts edges from reset deassert until Ready; also checks that no
    // valid result appears during init.
    task automatic wait_ready(input string name);
        int  n;
        bit  saw_valid;
        n = 0;
        saw_valid = 1'b0;
        while (bus.Ready !== 1'b1 && n < 300) begin
            step();
            n++;
            if (bus.InstrValid !== 1'b0) saw_valid = 1'b1;
        end
        chk({name, "_ready_cycles"}, n, 128);
        chk({name, "_no_valid_in_init"}, {31'b0, saw_valid}, 32'h0);
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_instr"}, bus.Instruction, 32'h0);
        chk({name, "_flags"}, {28'b0, bus.InstrValid, bus.AddrFault, bus.Ready, 1'b0}, 32'h0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;

        // addr fetch stall len laddr ldata | instr valid fault
        vecs.push_back('{32'h0000_0000, 1, 0, 0, 32'h0, 32'h0, 32'h0000_0000, 1, 0}); // idx 0
        vecs.push_back('{32'h0000_0100, 1, 0, 0, 32'h0, 32'h0, 32'h0000_00C0, 1, 0}); // idx 64
        vecs.push_back('{32'h0000_01FC, 1, 0, 0, 32'h0, 32'h0, 32'h0000_017D, 1, 0}); // idx 127
        vecs.push_back('{32'h0000_001C, 1, 0, 0, 32'h0, 32'h0, 32'h0000_0015, 1, 0});
        vecs.push_back('{32'h0000_0200, 1, 0, 0, 32'h0, 32'h0, 32'h0000_0000, 1, 1}); // range
        vecs.push_back('{32'h0000_001C, 1, 0, 0, 32'h0, 32'h0, 32'h0000_0015, 1, 0});
        vecs.push_back('{32'h0000_0006, 1, 0, 0, 32'h0, 32'h0, 32'h0000_0000, 1, 1}); // align
        vecs.push_back('{32'h8000_0000, 1, 0, 0, 32'h0, 32'h0, 32'h0000_0000, 1, 1}); // top bit
        vecs.push_back('{32'h0000_0008, 1, 0, 0, 32'h0, 32'h0, 32'h0000_0006, 1, 0});
        vecs.push_back('{32'h0000_0010, 1, 1, 0, 32'h0, 32'h0, 32'h0000_0006, 1, 0}); // stall x3
        vecs.push_back('{32'h0000_0010, 1, 1, 0, 32'h0, 32'h0, 32'h0000_0006, 1, 0});
        vecs.push_back('{32'h0000_0010, 1, 1, 0, 32'h0, 32'h0, 32'h0000_0006, 1, 0});
        vecs.push_back('{32'h0000_0010, 1, 0, 0, 32'h0, 32'h0, 32'h0000_000C, 1, 0});
        vecs.push_back('{32'h0000_0010, 0, 0, 0, 32'h0, 32'h0, 32'h0000_000C, 0, 0}); // no fetch
        vecs.push_back('{32'h0000_0040, 1, 0, 1, 32'h40, 32'h2002_000A, 32'h0000_0030, 1, 0}); // RBW
        vecs.push_back('{32'h0000_0040, 1, 0, 0, 32'h0, 32'h0, 32'h2002_000A, 1, 0});
        vecs.push_back('{32'h0000_0000, 0, 0, 1, 32'h41, 32'hDEAD_BEEF, 32'h2002_000A, 0, 0}); // misaligned load
        vecs.push_back('{32'h0000_0040, 1, 0, 0, 32'h0, 32'h0, 32'h2002_000A, 1, 0});
        vecs.push_back('{32'h0000_0000, 0, 0, 1, 32'h240, 32'hFFFF_FFFF, 32'h2002_000A, 0, 0}); // out-of-range load
        vecs.push_back('{32'h0000_0040, 1, 0, 0, 32'h0, 32'h0, 32'h2002_000A, 1, 0});
        vecs.push_back('{32'h0000_0044, 1, 1, 1, 32'h44, 32'h1111_1111, 32'h2002_000A, 1, 0}); // load under stall
        vecs.push_back('{32'h0000_0044, 1, 0, 0, 32'h0, 32'h0, 32'h1111_1111, 1, 0});

        // Reset state
        idle();
        Reset = 1'b1;
        step();
        step();
        chk_zero("reset");

        // Init with fetch and loads presented; both must be ignored
        Reset        = 1'b0;
        bus.Fetch    = 1'b1;
        bus.Address  = 32'h0000_001C;
        bus.LoadEn   = 1'b1;
        bus.LoadAddr = 32'h0000_0100;
        bus.LoadData = 32'hFFFF_FFFF;
        wait_ready("init");
        idle();

        // Table
        foreach (vecs[i]) begin
            bus.Address  = vecs[i].addr;
            bus.Fetch    = vecs[i].fetch;
            bus.Stall    = vecs[i].stall;
            bus.LoadEn   = vecs[i].len;
            bus.LoadAddr = vecs[i].laddr;
            bus.LoadData = vecs[i].ldata;
            step();
            chk($sformatf("vec%0d_instr", i), bus.Instruction, vecs[i].e_instr);
            chk($sformatf("vec%0d_vf", i), {30'b0, bus.InstrValid, bus.AddrFault},
                {30'b0, vecs[i].e_valid, vecs[i].e_fault});
        end
        idle();

        // Reset mid-fetch in READY; init must restore the word at 0x40
        bus.Fetch   = 1'b1;
        bus.Address = 32'h0000_001C;
        Reset       = 1'b1;
        step();
        chk_zero("rst_fetch");
        Reset = 1'b0;
        idle();
        wait_ready("rst_fetch");
        bus.Fetch   = 1'b1;
        bus.Address = 32'h0000_0040;
        step();
        chk("reinit_0x40", bus.Instruction, 32'h0000_0030);
        idle();

        // Reset at cnt=50 during init
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        for (int k = 0; k < 50; k++) step();
        chk("mid_init_not_ready", {31'b0, bus.Ready}, 32'h0);
        Reset = 1'b1;
        step();
        chk_zero("rst_init");
        Reset = 1'b0;
        wait_ready("rst_init");
        bus.Fetch   = 1'b1;
        bus.Address = 32'h0000_01FC;
        step();
        chk("post_init_127", bus.Instruction, 32'h0000_017D);
        idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
